// File: rtl/ssd_display_driver_pkg.sv
// Shared definitions for the seven-segment display driver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ssd_display_driver_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/ssd_display_driver_seg_decoder.sv
// BCD digit to active-low seven-segment code, with forced blanking.
// Latency: combinational.
// Backpressure: none.
// Ports: digit_i (4-bit BCD), blank_i (1 = all segments off), cathode_o ({g..a}, active low).
module ssd_display_driver_seg_decoder
    import ssd_display_driver_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] cathode_o
);

    always_comb begin
        cathode_o = SEG_BLANK;
        if (!blank_i) begin
            case (digit_i)
                4'd0:    cathode_o = SEG_0;
                4'd1:    cathode_o = SEG_1;
                4'd2:    cathode_o = SEG_2;
                4'd3:    cathode_o = SEG_3;
                4'd4:    cathode_o = SEG_4;
                4'd5:    cathode_o = SEG_5;
                4'd6:    cathode_o = SEG_6;
                4'd7:    cathode_o = SEG_7;
                4'd8:    cathode_o = SEG_8;
                4'd9:    cathode_o = SEG_9;
                default: cathode_o = SEG_BLANK; // 10..15 never produced by the converter
            endcase
        end
    end

endmodule

// File: rtl/ssd_display_driver.sv
// Binary-to-BCD conversion (sequential double dabble) and 4-digit multiplexed seven-segment scan.
// Latency: value change seen in IDLE at cycle N -> digits latched at end of cycle N+IN_W+1; anode/cathode registered (1 cycle).
// Backpressure: none; value changes during a conversion are picked up by the next IDLE compare.
// Ports: clk, reset (async, active high), value (binary in), anode/cathode (active low),
//        busy (conversion in progress), digits_valid (a conversion has completed since reset).
module ssd_display_driver
    import ssd_display_driver_pkg::*;
#(
    parameter int IN_W          = 13,
    parameter int REFRESH_DIV_W = 18,
    parameter int BLANK_LZ      = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IN_W-1:0] value,
    output logic [3:0]      anode,
    output logic [6:0]      cathode,
    output logic            busy,
    output logic            digits_valid
);

    localparam int ITER_W = $clog2(IN_W + 1);
    localparam int BCD_W  = 4 * NUM_DIGITS;

    state_t                   state_q, state_d;
    logic [IN_W-1:0]          shift_q, shift_d;
    logic [IN_W-1:0]          cap_q, cap_d;
    logic [IN_W-1:0]          last_q, last_d;
    logic [BCD_W-1:0]         bcd_q, bcd_d;
    logic [BCD_W-1:0]         bcd_adj;
    logic [BCD_W-1:0]         digits_q, digits_d;
    logic [ITER_W-1:0]        iter_q, iter_d;
    logic                     pending_q, pending_d;
    logic                     busy_q, busy_d;
    logic                     valid_q, valid_d;

    logic [REFRESH_DIV_W-1:0] refresh_q;
    logic [1:0]               sel;
    logic [3:0]               digit_sel;
    logic                     blank_sel;
    logic [6:0]               seg_cath;
    logic [3:0]               anode_q;
    logic [6:0]               cathode_q;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cap_d     = cap_q;
        last_d    = last_q;
        bcd_d     = bcd_q;
        digits_d  = digits_q;
        iter_d    = iter_q;
        pending_d = pending_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        case (state_q)
            IDLE: begin
                // pending forces one conversion after reset even if value equals last_q
                if (pending_q || (value != last_q)) begin
                    shift_d   = value;
                    cap_d     = value;
                    bcd_d     = '0;
                    iter_d    = '0;
                    pending_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // The bcd MSB shifted out is always 0: 4 digits cover the full input range.
                {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
                iter_d           = iter_q + 1'b1;
                if (iter_q == ITER_W'(IN_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                digits_d = bcd_q;
                last_d   = cap_q;
                busy_d   = 1'b0;
                valid_d  = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cap_q     <= '0;
            last_q    <= '0;
            bcd_q     <= '0;
            digits_q  <= '0;
            iter_q    <= '0;
            pending_q <= 1'b1;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cap_q     <= cap_d;
            last_q    <= last_d;
            bcd_q     <= bcd_d;
            digits_q  <= digits_d;
            iter_q    <= iter_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
        end
    end

    // Scan: top two refresh bits pick the digit; only latched digits are shown.
    assign sel       = refresh_q[REFRESH_DIV_W-1 -: 2];
    assign digit_sel = digits_q[{sel, 2'b00} +: 4];

    // Digit i >= 1 is a leading zero when it and every digit above it are zero.
    always_comb begin
        blank_sel = 1'b0;
        if ((BLANK_LZ != 0) && (sel != 2'd0)) begin
            blank_sel = 1'b1;
            for (int i = 1; i < NUM_DIGITS; i++) begin
                if ((i >= int'(sel)) && (digits_q[4*i +: 4] != 4'd0)) begin
                    blank_sel = 1'b0;
                end
            end
        end
    end

    ssd_display_driver_seg_decoder u_seg_decoder (
        .digit_i   (digit_sel),
        .blank_i   (blank_sel),
        .cathode_o (seg_cath)
    );

    // anode and cathode are registered together so they always switch on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_q <= '0;
            anode_q   <= 4'b1110;
            cathode_q <= SEG_0;
        end else begin
            refresh_q <= refresh_q + 1'b1;
            anode_q   <= ~(4'b0001 << sel);
            cathode_q <= seg_cath;
        end
    end

    assign anode        = anode_q;
    assign cathode      = cathode_q;
    assign busy         = busy_q;
    assign digits_valid = valid_q;

endmodule

// File: doc/ssd_display_driver.md
Name: ssd_display_driver

Overview:
- Downstream consumer of the DataPath 13-bit ssd value; drives a 4-digit multiplexed seven-segment display on the board.
- Converts the binary value (0..8191) to four BCD digits with a sequential double-dabble FSM.
- Scans the digits with a refresh counter and drives active-low anode and cathode lines.
- Replaces direct use of the SSD_Clock input as the digit-scan clock; everything runs on the single system clock.

Parameters:
- IN_W, 13: width of the binary input value.
- REFRESH_DIV_W, 18: width of the refresh counter; its top 2 bits select the active digit.
- BLANK_LZ, 1: 1 blanks leading-zero digits 3..1; digit 0 is never blanked.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  reset.
- value  in  IN_W  binary value to display (DataPath ssd output).
- anode  out  4  digit enables, active low; bit i = digit i (0 = least significant).
- cathode  out  7  segments {g,f,e,d,c,b,a}, active low.
- busy  out  1  high while a conversion is in progress.
- digits_valid  out  1  high once at least one conversion has completed since reset.

Behaviour:
- Clocking/reset: one clock, clk; reset is asynchronous, active-high. All registers clear immediately on reset assertion.
- Reset values:
  - anode = 4'b1110; cathode = 7'b1000000 (digit "0").
  - busy = 0; digits_valid = 0.
  - display digit registers = 0; last_value = 0; pending = 1; refresh counter = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If pending=1 or value != last_value: capture value into shift_reg, clear the 16-bit BCD accumulator, set iter=0, clear pending, set busy=1, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT (one iteration per cycle):
  - For each BCD nibble >= 5, add 3.
  - Then shift {bcd, shift_reg} left by 1 and increment iter.
  - After the IN_W-th iteration, go to DONE.
- DONE (one cycle):
  - Latch the BCD nibbles into the display digit registers; last_value <= captured value.
  - busy=0; digits_valid=1; go to IDLE.
- Latency: value change sampled in IDLE at cycle N -> display registers updated at end of cycle N+IN_W+1 (15 cycles for IN_W=13).
- Input changes during SHIFT/DONE are ignored by the conversion in flight. The change is detected in the next IDLE cycle by the compare against last_value, so the final value is always displayed.
- Arithmetic: 4 nibbles cover 0..9999, so every 13-bit input fits and there is no overflow case. The add-3 is applied before the shift on every iteration, including the last.
- Refresh:
  - The counter increments every cycle and wraps from all-ones to 0.
  - sel = counter[REFRESH_DIV_W-1 -: 2]; anode = ~(4'b0001 << sel).
  - cathode = decode(digit[sel]), registered, so it aligns with the registered anode with 1 cycle latency after sel changes.
- Blanking (BLANK_LZ=1): digit i (i >= 1) is blanked (cathode = 7'b1111111) when digits i..3 are all zero. Blanking uses the latched display digits only.
- Segment codes (active low, gfedcba):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - nibble values 10..15 = 1111111 (unreachable; defined for safety).
- Reset mid-conversion: the conversion is aborted, outputs return to reset values, and pending=1 forces a fresh conversion of the current value on the first cycle after release.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE/SHIFT/DONE);
  - seven-segment code constants SEG_0..SEG_9 and SEG_BLANK;
  - NUM_DIGITS=4.
- One sub-module: seg_decoder, purely combinational, 4-bit digit plus blank in -> 7-bit active-low cathode. It is instantiated once, on the scan-selected digit.

Test Plan (REFRESH_DIV_W=4 for speed):
- Assert reset with value=0, then release -> anode=1110 and cathode=1000000 during reset; busy=1 in the first cycle after release, 0 after 15 cycles; digits_valid=1; digits 3..1 blank (1111111), digit 0 shows 1000000.
- value=8191 after idle -> busy high for 14 cycles; latched digits 8,1,9,1. During the sel=3 window (anode=0111) cathode=0000000; during sel=0 cathode=1111001.
- value=1234, then value=42 on the 5th SHIFT cycle -> display first shows 1,2,3,4; busy then re-asserts immediately; 15 cycles later it shows blank, blank, 4 (0011001), 2 (0100100).
- Reset asserted mid-SHIFT while converting 5000 -> outputs return to reset values on the same edge; after release the display converges to 5,0,0,0 with no leading blanking (digit 3 non-zero).
- Hold value constant for 64 cycles -> busy stays 0. anode cycles 1110->1101->1011->0111 every 4 cycles and wraps to 1110. cathode never changes in the cycle its anode is active except at the registered 1-cycle boundary.
